cp0_reg: RTL

- MIPS CP0 register file in the WB boundary, directly downstream of the MEM-stage exception resolver.
- Consumes the resolved exception vector, the delay-slot flag, the faulting PC and MTC0 writes.
- Holds Status, Cause, EPC, BadVAddr, Count and Compare.
- Feeds current Status/Cause/EPC back to the exception resolver and serves MFC0 reads.

---
 rtl/cp0_reg_pkg.sv | 44 ++++
 rtl/cp0_timer.sv | 50 +++++
 rtl/cp0_reg.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: pipeline exception flags, ExcCodes, register numbers
// and Status/Cause bit positions.
package cp0_reg_pkg;

  typedef struct packed {
    logic Interrupt;
    logic WrongAddressinIF;
    logic ReservedInstruction;
    logic Syscall;
    logic Break;
    logic Overflow;
    logic WrWrongAddressinMEM;
    logic RdWrongAddressinMEM;
    logic Eret;
  } ExceptinPipeType;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;
  localparam int STATUS_BEV   = 22;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IP_SW  = 9;
  localparam int CAUSE_IV     = 23;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with prescaler and TI flag.
// Present only when CP0_TIMER_EN is defined.
`ifdef CP0_TIMER_EN
module cp0_timer
  import cp0_reg_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cp0_wr_i,
  input  logic [4:0]  cp0_wr_addr_i,
  input  logic [31:0] cp0_wr_data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic phase;
  logic tick;
  logic wr_count;
  logic wr_compare;

  assign wr_count   = cp0_wr_i && (cp0_wr_addr_i == CP0_REG_COUNT);
  assign wr_compare = cp0_wr_i && (cp0_wr_addr_i == CP0_REG_COMPARE);
  assign tick       = (COUNT_DIV == 1) || phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_o   <= '0;
      compare_o <= '0;
      phase     <= 1'b0;
      ti_o      <= 1'b0;
    end else begin
      if (wr_count) begin
        count_o <= cp0_wr_data_i;
        phase   <= 1'b0;
      end else begin
        if (tick) count_o <= count_o + 32'd1;
        phase <= (COUNT_DIV == 1) ? 1'b0 : ~phase;
      end
      if (wr_compare) compare_o <= cp0_wr_data_i;
      // a Compare write acknowledges the interrupt even against a same-cycle match
      if (wr_compare)                 ti_o <= 1'b0;
      else if (count_o == compare_o)  ti_o <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/cp0_reg.sv
// MIPS CP0 register file (Status, Cause, EPC, BadVAddr, optional Count/Compare).
// Timer built only when CP0_TIMER_EN is defined.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter int          COUNT_DIV  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      ext_int_i,
  input  logic            cp0_wr_i,
  input  logic [4:0]      cp0_wr_addr_i,
  input  logic [31:0]     cp0_wr_data_i,
  input  logic [4:0]      cp0_rd_addr_i,
  output logic [31:0]     cp0_rd_data_o,
  input  ExceptinPipeType except_type_i,
  input  logic            is_delay_slot_i,
  input  logic [31:0]     current_pc_i,
  input  logic [31:0]     bad_vaddr_i,
  output logic [31:0]     cp0_status_o,
  output logic [31:0]     cp0_cause_o,
  output logic [31:0]     cp0_epc_o,
  output logic [31:0]     cp0_badvaddr_o,
  output logic            timer_int_o
);

  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_iv;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exc;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;

`ifdef CP0_TIMER_EN
  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk           (clk),
    .rst           (rst),
    .cp0_wr_i      (cp0_wr_i),
    .cp0_wr_addr_i (cp0_wr_addr_i),
    .cp0_wr_data_i (cp0_wr_data_i),
    .count_o       (count),
    .compare_o     (compare),
    .ti_o          (ti)
  );
`else
  logic unused_count_div;
  assign unused_count_div = |COUNT_DIV;
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif

  logic        exc_any;
  logic [4:0]  exc_code;
  logic        badv_upd;
  logic [31:0] badv_val;

  always_comb begin
    exc_any  = except_type_i.Interrupt | except_type_i.WrongAddressinIF |
               except_type_i.ReservedInstruction | except_type_i.Syscall |
               except_type_i.Break | except_type_i.Overflow |
               except_type_i.WrWrongAddressinMEM | except_type_i.RdWrongAddressinMEM;
    exc_code = EXC_INT;
    badv_upd = 1'b0;
    badv_val = bad_vaddr_i;
    if (except_type_i.Interrupt) begin
      exc_code = EXC_INT;
    end else if (except_type_i.WrongAddressinIF) begin
      exc_code = EXC_ADEL;
      badv_upd = 1'b1;
      badv_val = current_pc_i;
    end else if (except_type_i.ReservedInstruction) begin
      exc_code = EXC_RI;
    end else if (except_type_i.Syscall) begin
      exc_code = EXC_SYS;
    end else if (except_type_i.Break) begin
      exc_code = EXC_BP;
    end else if (except_type_i.Overflow) begin
      exc_code = EXC_OV;
    end else if (except_type_i.WrWrongAddressinMEM) begin
      exc_code = EXC_ADES;
      badv_upd = 1'b1;
    end else if (except_type_i.RdWrongAddressinMEM) begin
      exc_code = EXC_ADEL;
      badv_upd = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_im   <= STATUS_RST[STATUS_IM_HI:STATUS_IM_LO];
      status_exl  <= STATUS_RST[STATUS_EXL];
      status_ie   <= STATUS_RST[STATUS_IE];
      cause_bd    <= 1'b0;
      cause_iv    <= 1'b0;
      cause_ip_hw <= '0;
      cause_ip_sw <= '0;
      cause_exc   <= '0;
      epc         <= '0;
      badvaddr    <= '0;
    end else begin
      cause_ip_hw <= {ext_int_i[5] | ti, ext_int_i[4:0]};
      if (cp0_wr_i) begin
        case (cp0_wr_addr_i)
          CP0_REG_STATUS: begin
            status_im  <= cp0_wr_data_i[STATUS_IM_HI:STATUS_IM_LO];
            status_exl <= cp0_wr_data_i[STATUS_EXL];
            status_ie  <= cp0_wr_data_i[STATUS_IE];
          end
          CP0_REG_CAUSE: begin
            cause_ip_sw <= cp0_wr_data_i[CAUSE_IP_SW:CAUSE_IP_LO];
            cause_iv    <= cp0_wr_data_i[CAUSE_IV];
          end
          CP0_REG_EPC: if (!exc_any) epc <= cp0_wr_data_i;
          default: ;
        endcase
      end
      // placed after the MTC0 decode so the exception's EXL update takes precedence
      if (exc_any) begin
        cause_exc  <= exc_code;
        status_exl <= 1'b1;
        if (!status_exl) begin
          epc      <= is_delay_slot_i ? current_pc_i - 32'd4 : current_pc_i;
          cause_bd <= is_delay_slot_i;
        end
        if (badv_upd) badvaddr <= badv_val;
      end else if (except_type_i.Eret) begin
        status_exl <= 1'b0;
      end
    end
  end

  assign cp0_status_o   = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
  assign cp0_cause_o    = {cause_bd, ti, 6'b0, cause_iv, 7'b0, cause_ip_hw, cause_ip_sw,
                           1'b0, cause_exc, 2'b0};
  assign cp0_epc_o      = epc;
  assign cp0_badvaddr_o = badvaddr;
  assign timer_int_o    = ti;

  always_comb begin
    case (cp0_rd_addr_i)
      CP0_REG_BADVADDR: cp0_rd_data_o = badvaddr;
      CP0_REG_COUNT:    cp0_rd_data_o = count;
      CP0_REG_COMPARE:  cp0_rd_data_o = compare;
      CP0_REG_STATUS:   cp0_rd_data_o = cp0_status_o;
      CP0_REG_CAUSE:    cp0_rd_data_o = cp0_cause_o;
      CP0_REG_EPC:      cp0_rd_data_o = epc;
      default:          cp0_rd_data_o = '0;
    endcase
  end

endmodule
